// File: rtl/dpll_pkg.sv
// Shared definitions for the dpll_prog all-digital PLL: default parameter
// values, configuration minimums, the ID-counter action encoding and small
// arithmetic helpers.
package dpll_pkg;

    localparam int unsigned DEF_K_W      = 8;
    localparam int unsigned DEF_N_W      = 9;
    localparam int unsigned DEF_ID_W     = 3;
    localparam int unsigned DEF_K_DEF    = 4;
    localparam int unsigned DEF_N_DEF    = 16;
    localparam int unsigned DEF_LOCK_W   = 9;
    localparam int unsigned DEF_LOCK_TOL = 4;
    localparam int unsigned DEF_LOCK_CNT = 4;

    localparam int unsigned K_MIN = 2;
    localparam int unsigned N_MIN = 2;

    // What the ID counter does this cycle.
    typedef enum logic [1:0] {
        ID_STEP = 2'd0,   // nominal +1
        ID_SKIP = 2'd1,   // +2, applies a pending increment
        ID_HOLD = 2'd2    // +0, applies a pending decrement
    } id_act_e;

    function automatic int unsigned clamp_min(input int unsigned v, input int unsigned lo);
        return (v < lo) ? lo : v;
    endfunction

    function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/dpll_lock_det.sv
// Lock detector: measures consecutive dpout high/low run lengths with
// saturating counters and qualifies lock after LOCK_CNT consecutive edges
// whose last high and low runs differ by at most LOCK_TOL cycles.
module dpll_lock_det
    import dpll_pkg::*;
#(
    parameter int unsigned LOCK_W   = DEF_LOCK_W,
    parameter int unsigned LOCK_TOL = DEF_LOCK_TOL,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic clk,
    input  logic reset,
    input  logic dpout,
    input  logic clr,
    output logic syn
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam logic [LOCK_W-1:0] SAT = '1;

    logic [LOCK_W-1:0] hi_cnt;
    logic [LOCK_W-1:0] lo_cnt;
    logic [GW-1:0]     good_cnt;
    logic              dp_q;
    logic              dp_edge;
    logic              cmp_good;
    logic              saturated;

    // Edge detect and tolerance comparison on the current run lengths.
    always_comb begin
        dp_edge   = dpout ^ dp_q;
        cmp_good  = abs_diff(32'(hi_cnt), 32'(lo_cnt)) <= LOCK_TOL;
        saturated = (hi_cnt == SAT) || (lo_cnt == SAT);
    end

    // Run-length counters restart at 1 on the edge that begins a new run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_q   <= 1'b0;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            dp_q <= dpout;
            if (dp_edge) begin
                if (dpout) hi_cnt <= LOCK_W'(1);
                else       lo_cnt <= LOCK_W'(1);
            end else if (dpout) begin
                if (hi_cnt != SAT) hi_cnt <= hi_cnt + LOCK_W'(1);
            end else begin
                if (lo_cnt != SAT) lo_cnt <= lo_cnt + LOCK_W'(1);
            end
        end
    end

    // Qualification counter, saturating at LOCK_CNT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            good_cnt <= '0;
        end else if (clr || saturated || (dp_edge && !cmp_good)) begin
            good_cnt <= '0;
        end else if (dp_edge && (good_cnt != GW'(LOCK_CNT))) begin
            good_cnt <= good_cnt + GW'(1);
        end
    end

    assign syn = (good_cnt == GW'(LOCK_CNT));

endmodule

// File: rtl/dpll_prog.sv
// dpll_prog: all-digital PLL (XOR phase detector, K up/down counter,
// ID counter, divide-by-N on a clock enable) with runtime K/N, an input
// synchroniser and a lock detector.
// Optional macro DPLL_LOCK_HOLD_EN: ignore carry/borrow while syn=1.
module dpll_prog
    import dpll_pkg::*;
#(
    parameter int unsigned K_W      = DEF_K_W,
    parameter int unsigned N_W      = DEF_N_W,
    parameter int unsigned ID_W     = DEF_ID_W,
    parameter int unsigned K_DEF    = DEF_K_DEF,
    parameter int unsigned N_DEF    = DEF_N_DEF,
    parameter int unsigned LOCK_W   = DEF_LOCK_W,
    parameter int unsigned LOCK_TOL = DEF_LOCK_TOL,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           signal_in,
    input  logic [K_W-1:0] k_cfg,
    input  logic [N_W-1:0] n_cfg,
    input  logic           cfg_load,
    output logic           signal_out,
    output logic           syn,
    output logic           dpout
);

    logic            sin_m, sin_s;
    logic [K_W-1:0]  k_act, cnt_k;
    logic            carry, borrow, carry_eff, borrow_eff;
    logic            inc_pend, dec_pend, inc_nxt, dec_nxt;
    logic [ID_W-1:0] id_cnt, id_nxt;
    logic            msb_q, en;
    logic [N_W-1:0]  n_act, n_stg, cnt_n, n_half;
    logic            n_pend;
    id_act_e         id_act;

    // Input synchroniser and registered XOR phase detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sin_m <= 1'b0;
            sin_s <= 1'b0;
            dpout <= 1'b0;
        end else begin
            sin_m <= signal_in;
            sin_s <= sin_m;
            dpout <= sin_s ^ signal_out;
        end
    end

    // K modulus counter; a load installs the new K and restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_act  <= K_W'(K_DEF);
            cnt_k  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else if (cfg_load) begin
            k_act  <= K_W'(clamp_min(32'(k_cfg), K_MIN));
            cnt_k  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else if (dpout) begin
            borrow <= 1'b0;
            carry  <= (cnt_k == k_act - K_W'(1));
            cnt_k  <= (cnt_k == k_act - K_W'(1)) ? '0 : cnt_k + K_W'(1);
        end else begin
            carry  <= 1'b0;
            borrow <= (cnt_k == '0);
            cnt_k  <= (cnt_k == '0) ? k_act - K_W'(1) : cnt_k - K_W'(1);
        end
    end

    // ID action selection and next pending flags; simultaneous pending
    // increment and decrement cancel each other.
    always_comb begin
        carry_eff  = carry;
        borrow_eff = borrow;
`ifdef DPLL_LOCK_HOLD_EN
        if (syn) begin
            carry_eff  = 1'b0;
            borrow_eff = 1'b0;
        end
`endif
        id_act = ID_STEP;
        if (inc_pend)      id_act = ID_SKIP;
        else if (dec_pend) id_act = ID_HOLD;
        case (id_act)
            ID_SKIP: id_nxt = id_cnt + ID_W'(2);
            ID_HOLD: id_nxt = id_cnt;
            default: id_nxt = id_cnt + ID_W'(1);
        endcase
        inc_nxt = carry_eff  | (inc_pend & (id_act != ID_SKIP));
        dec_nxt = borrow_eff | (dec_pend & (id_act != ID_HOLD));
        if (inc_nxt && dec_nxt) begin
            inc_nxt = 1'b0;
            dec_nxt = 1'b0;
        end
        n_half = (n_act - N_W'(1)) >> 1;
    end

    // ID counter, pending flags and enable pulse on the MSB rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_cnt   <= '0;
            inc_pend <= 1'b0;
            dec_pend <= 1'b0;
            msb_q    <= 1'b0;
            en       <= 1'b0;
        end else begin
            id_cnt   <= id_nxt;
            inc_pend <= inc_nxt;
            dec_pend <= dec_nxt;
            msb_q    <= id_cnt[ID_W-1];
            en       <= id_cnt[ID_W-1] & ~msb_q;
        end
    end

    // Divide-by-N; a staged N is only installed at the wrap so no runt
    // period appears. A load in the wrap cycle stays pending for the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_n      <= '0;
            signal_out <= 1'b0;
            n_act      <= N_W'(N_DEF);
            n_stg      <= N_W'(N_DEF);
            n_pend     <= 1'b0;
        end else begin
            if (en) begin
                if (cnt_n == n_act - N_W'(1)) begin
                    cnt_n      <= '0;
                    signal_out <= 1'b0;
                    if (n_pend) begin
                        n_act  <= n_stg;
                        n_pend <= 1'b0;
                    end
                end else begin
                    cnt_n <= cnt_n + N_W'(1);
                    if (cnt_n == n_half) signal_out <= 1'b1;
                end
            end
            if (cfg_load) begin
                n_stg  <= N_W'(clamp_min(32'(n_cfg), N_MIN));
                n_pend <= 1'b1;
            end
        end
    end

    dpll_lock_det #(
        .LOCK_W   (LOCK_W),
        .LOCK_TOL (LOCK_TOL),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock_det (
        .clk   (clk),
        .reset (reset),
        .dpout (dpout),
        .clr   (cfg_load),
        .syn   (syn)
    );

endmodule
